sram_axi_bridge: RTL and testbench
==================================

// Module: sram_axi_bridge
// PURPOSE
//  Converts one single-cycle SRAM-style CPU port (inst or data, after the MMU) into a single-beat AXI4 master.
//  Sits directly downstream of the CPU core's physical-address SRAM port.
//  Holds the pipeline via cpu_stall until each transfer completes.
//  Instantiated once per port: inst and data, with different AXI IDs.
// PARAMETERS
//  AXI_ID   4'h0  value driven on arid/awid
// PORTS
//  clk        in   1   clock; all state on rising edge
//  resetn     in   1   asynchronous, active-low reset
//  cpu_en     in   1   request valid; held stable with wen/addr/wdata while cpu_stall=1
//  cpu_wen    in   4   byte write strobes; 0 = read
//  cpu_addr   in   32  physical address
//  cpu_wdata  in   32  write data
//  cpu_rdata  out  32  read data, valid in DONE cycle
//  cpu_stall  out  1   1 = request not yet complete
//  arid/araddr/arlen/arsize/arburst  out  4/32/8/3/2  AR channel payload
//  arvalid    out  1   AR valid
//  arready    in   1   AR ready
//  rid/rdata/rresp/rlast  in  4/32/2/1  R channel payload
//  rvalid     in   1   R valid
//  rready     out  1   R ready
//  awid/awaddr/awlen/awsize/awburst  out  4/32/8/3/2  AW channel payload
//  awvalid    out  1   AW valid
//  awready    in   1   AW ready
//  wdata/wstrb/wlast  out  32/4/1  W channel payload
//  wvalid     out  1   W valid
//  wready     in   1   W ready
//  bid/bresp  in   4/2  B channel payload
//  bvalid     in   1   B valid
//  bready     out  1   B ready
// BEHAVIOUR
//  Reset: state=IDLE; all valids and readies = 0; cpu_rdata=0; internal flags cleared.
//  cpu_stall = cpu_en & (state!=DONE), combinational; it also covers the IDLE cycle a request arrives.
//  FSM states: IDLE, RD_AR, RD_R, WR_AWW, WR_B, DONE.
//   IDLE:  cpu_en & wen==0 -> RD_AR.
//          cpu_en & wen!=0 -> WR_AWW.
//          Payload is latched on entry; AXI outputs come from registers only.
//   RD_AR: arvalid=1; on arready -> RD_R.
//   RD_R:  rready=1; on rvalid, capture rdata -> DONE.
//   WR_AWW: awvalid and wvalid both assert on entry.
//          Each drops independently after its own handshake (aw_done/w_done flags).
//          Handshakes may complete in the same cycle or in either order.
//          Both done -> WR_B.
//   WR_B:  bready=1; on bvalid -> DONE.
//   DONE:  one cycle, cpu_stall=0; -> IDLE. A request present in DONE is not reissued.
//  Fixed payload: len=0, burst=2'b01, wlast=1, wstrb=cpu_wen, arsize=3'd2.
//  awsize from wen:
//   4'b1111 -> 2.
//   4'b0011 / 4'b1100 -> 1.
//   one-hot -> 0.
//   other values are illegal; drive 2.
//  Addresses are passed unmodified.
//  Non-OKAY rresp/bresp: the transfer still completes and data is returned as-is.
//  rid/bid are not checked; single outstanding transaction only.
//  Valid, once asserted, holds until ready (AXI rule); payload stays stable.
//  A resetn drop mid-transfer aborts immediately to IDLE with valids low. The interconnect shares this reset.
//  Latency with zero-wait slave:
//   read  = 4 cycles request-to-DONE (IDLE, AR, R, DONE).
//   write = 4 cycles.
// CONFIGURATION
//  BRIDGE_POSTED_WRITE_EN defined:
//   WR_AWW with both handshakes done -> DONE directly; sets b_pending.
//   bready=1 whenever b_pending; bvalid clears b_pending.
//   IDLE does not accept any new request while b_pending=1 (stall stays 1).
//   WR_B is unused.
//  Undefined: writes wait for B as above.
// TESTING
//  1. Read 0x1FC0_0000, arready 2 cycles late, rvalid 3 cycles after AR -> stall high 7 cycles; DONE rdata=0xDEADBEEF; arlen=0, arsize=2.
//  2. Byte write wen=4'b0100 addr 0x0000_1012 data 0x00AB_0000 -> awsize=0, wstrb=0100, wlast=1; stall drops the cycle after bvalid.
//  3. Write with wready before awready (2 cycles apart) -> wvalid drops first, awvalid held; single B; completes once.
//  4. Back-to-back read, write, read, cpu_en held -> three distinct AXI transactions, none duplicated in DONE.
//  5. resetn low during RD_R -> all valids 0, cpu_stall follows cpu_en, state IDLE after release.
//  6. BRIDGE_POSTED_WRITE_EN: write, then read; bvalid 5 cycles late -> write DONE before B; read arvalid only after bvalid.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Turns one single-cycle SRAM-style CPU port (inst or data side, after the
//   MMU) into a single-beat AXI4 master. Only one transaction is in flight at a
//   time. The CPU pipeline is held through cpu_stall until the transfer
//   reaches DONE.
//
//   Ports:
//     clk, resetn          clock and asynchronous active-low reset
//     cpu_en/wen/addr/wdata  request; held stable while cpu_stall=1
//     cpu_rdata, cpu_stall   read data (valid in DONE) and hold
//     ar*/r*, aw*/w*/b*      AXI4 master channels, single beat, id = AXI_ID
//
//   Optional build macro BRIDGE_POSTED_WRITE_EN:
//     writes complete towards the CPU once AW and W are accepted. The B
//     response is collected in the background (bready doubles as the
//     b_pending flag). No new request is accepted until that B arrives.
module sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_AR  = 3'd1;
  localparam logic [2:0] S_RD_R   = 3'd2;
  localparam logic [2:0] S_WR_AWW = 3'd3;
  localparam logic [2:0] S_WR_B   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  awsize_q, awsize_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        accept, aw_fin, w_fin;

  // Response ids/status are not checked: one transaction outstanding, and
  // error responses still complete with whatever data came back.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  // Transfer size from the byte strobes; illegal strobe patterns use word size.
  function automatic logic [2:0] size_of(input logic [3:0] wen);
    case (wen)
      4'b1111:                            size_of = 3'd2;
      4'b0011, 4'b1100:                   size_of = 3'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_of = 3'd0;
      default:                            size_of = 3'd2;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awsize_d  = awsize_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
`ifdef BRIDGE_POSTED_WRITE_EN
    accept    = cpu_en & ~bready_q;
`else
    accept    = cpu_en;
`endif
    // AW and W may be accepted in either order or together.
    aw_fin    = aw_done_q | (awvalid_q & awready);
    w_fin     = w_done_q  | (wvalid_q & wready);

    case (state_q)
      S_IDLE: if (accept) begin
        addr_d = cpu_addr;
        if (cpu_wen == 4'b0000) begin
          arvalid_d = 1'b1;
          state_d   = S_RD_AR;
        end else begin
          wdata_d   = cpu_wdata;
          wstrb_d   = cpu_wen;
          awsize_d  = size_of(cpu_wen);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_AWW;
        end
      end
      S_RD_AR: if (arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = S_RD_R;
      end
      S_RD_R: if (rvalid) begin
        rready_d = 1'b0;
        rdata_d  = rdata;
        state_d  = S_DONE;
      end
      S_WR_AWW: begin
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_fin && w_fin) begin
          bready_d = 1'b1;
`ifdef BRIDGE_POSTED_WRITE_EN
          state_d  = S_DONE;
`else
          state_d  = S_WR_B;
`endif
        end
      end
      S_WR_B: if (bvalid) begin
        bready_d = 1'b0;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef BRIDGE_POSTED_WRITE_EN
    // Background B collection, independent of the CPU-facing state.
    if (bready_q && bvalid) bready_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awsize_q  <= 3'd2;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awsize_q  <= awsize_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
    end
  end

  // Stall also covers the IDLE cycle in which a request first shows up.
  assign cpu_stall = cpu_en & (state_q != S_DONE);
  assign cpu_rdata = rdata_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = awsize_q;
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge
//   Scoreboard bench for sram_axi_bridge. The CPU driver pushes the expected
//   AXI beats and CPU completion into queues when a request is issued. A
//   randomised AXI slave pops and compares at each handshake, and a DONE
//   monitor compares returned read data. Reference memory (word array with
//   byte merge) is independent of the slave's own memory.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

`ifdef BRIDGE_POSTED_WRITE_EN
  localparam int WR_LAT = 2;
`else
  localparam int WR_LAT = 3;
`endif

  sram_axi_bridge #(.AXI_ID(4'h3)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [31:0] addr; logic [2:0] size; } aw_exp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;
  typedef struct { logic is_wr; logic [31:0] rdata; } done_exp_t;

  logic [31:0] exp_ar[$];
  aw_exp_t     exp_aw[$];
  w_exp_t      exp_w[$];
  done_exp_t   exp_done[$];

  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] slv_mem [logic [29:0]];

  function automatic logic [31:0] init_word(input logic [29:0] k);
    return {k[13:0], 2'b10, k[15:0]} ^ 32'hC3A5_0F96;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return init_word(a[31:2]);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    if (slv_mem.exists(a[31:2])) return slv_mem[a[31:2]];
    return init_word(a[31:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [2:0] exp_size(input logic [3:0] wen);
    if (wen == 4'hF) return 3'd2;
    if (wen == 4'h3 || wen == 4'hC) return 3'd1;
    if ($onehot(wen)) return 3'd0;
    return 3'd2;
  endfunction

  // ---------------- AXI slave / channel monitor ----------------
  bit          zero_wait = 1'b1, hold_r = 1'b0;
  bit          r_pend, b_pend, r_hs, b_hs, aw_seen, w_seen, ar_wait, aw_wait, w_wait;
  int          r_cnt, b_cnt;
  logic [31:0] r_val, aw_addr_s, w_data_s, ar_wait_addr, aw_wait_addr, w_wait_data;
  logic [3:0]  w_strb_s;

  initial begin
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    rdata = '0; rid = '0; rresp = '0; rlast = 0; bid = '0; bresp = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        {r_pend, b_pend, r_hs, b_hs, aw_seen, w_seen, ar_wait, aw_wait, w_wait} = '0;
        continue;
      end
      if (r_hs) begin rvalid = 0; r_hs = 0; end
      if (b_hs) begin bvalid = 0; b_hs = 0; end
      if (r_pend && !hold_r) begin
        if (r_cnt == 0) begin
          rvalid = 1; rdata = r_val; rlast = 1; r_pend = 0;
          rresp = 2'($urandom_range(0, 3)); rid = 4'($urandom_range(0, 15));
        end else r_cnt--;
      end
      if (b_pend) begin
        if (b_cnt == 0) begin
          bvalid = 1; b_pend = 0;
          bresp = 2'($urandom_range(0, 3)); bid = 4'($urandom_range(0, 15));
        end else b_cnt--;
      end
      // a valid left waiting last cycle must still be up with the same payload
      if (ar_wait) begin chk("arvalid_hold", 32'(arvalid), 1); chk("araddr_stable", araddr, ar_wait_addr); end
      if (aw_wait) begin chk("awvalid_hold", 32'(awvalid), 1); chk("awaddr_stable", awaddr, aw_wait_addr); end
      if (w_wait)  begin chk("wvalid_hold", 32'(wvalid), 1);  chk("wdata_stable", wdata, w_wait_data); end

      arready = arvalid && (zero_wait || $urandom_range(0, 2) == 0);
      awready = awvalid && (zero_wait || $urandom_range(0, 2) == 0);
      wready  = wvalid  && (zero_wait || $urandom_range(0, 2) == 0);

      if (arvalid && arready) begin
        chk("ar_while_write_open", 32'({aw_seen, w_seen, b_pend, bvalid}), 0);
        if (exp_ar.size() == 0) begin
          checks++; errors++;
          $display("FAIL ar_unexpected: got addr %h required none", araddr);
        end else begin
          chk("araddr", araddr, exp_ar.pop_front());
          chk("ar_fixed", 32'({arid, arlen, arsize, arburst}), 32'({4'h3, 8'd0, 3'd2, 2'b01}));
        end
        r_val = slv_rd(araddr);
        r_cnt = zero_wait ? 0 : $urandom_range(0, 3);
        r_pend = 1;
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_unexpected: got addr %h required none", awaddr);
        end else begin
          aw_exp_t e;
          e = exp_aw.pop_front();
          chk("awaddr", awaddr, e.addr);
          chk("awsize", 32'(awsize), 32'(e.size));
          chk("aw_fixed", 32'({awid, awlen, awburst}), 32'({4'h3, 8'd0, 2'b01}));
        end
        aw_seen = 1; aw_addr_s = awaddr;
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected: got data %h required none", wdata);
        end else begin
          w_exp_t e;
          e = exp_w.pop_front();
          chk("wdata", wdata, e.data);
          chk("wstrb_wlast", 32'({wstrb, wlast}), 32'({e.strb, 1'b1}));
        end
        w_seen = 1; w_data_s = wdata; w_strb_s = wstrb;
      end
      if (aw_seen && w_seen) begin
        slv_mem[aw_addr_s[31:2]] = merge(slv_rd(aw_addr_s), w_data_s, w_strb_s);
        b_pend = 1; b_cnt = zero_wait ? 0 : $urandom_range(0, 5);
        aw_seen = 0; w_seen = 0;
      end
      ar_wait = arvalid && !arready; ar_wait_addr = araddr;
      aw_wait = awvalid && !awready; aw_wait_addr = awaddr;
      w_wait  = wvalid && !wready;   w_wait_data  = wdata;
      r_hs = rvalid && rready;
      b_hs = bvalid && bready;
    end
  end

  // ---------------- CPU completion monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && cpu_en && !cpu_stall) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got completion required none at %0t", $time);
        end else begin
          done_exp_t d;
          d = exp_done.pop_front();
          if (!d.is_wr) chk("cpu_rdata", cpu_rdata, d.rdata);
          else checks++;
        end
      end
    end
  end

  // ---------------- CPU driver ----------------
  task automatic issue(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
    done_exp_t d;
    if (wen == 4'h0) begin
      exp_ar.push_back(addr);
      d.is_wr = 1'b0; d.rdata = ref_rd(addr);
    end else begin
      aw_exp_t a;
      w_exp_t  w;
      a.addr = addr; a.size = exp_size(wen);
      w.data = wd;   w.strb = wen;
      exp_aw.push_back(a); exp_w.push_back(w);
      ref_mem[addr[31:2]] = merge(ref_rd(addr), wd, wen);
      d.is_wr = 1'b1; d.rdata = '0;
    end
    exp_done.push_back(d);
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wd;
  endtask

  // Called just after a rising edge; returns with cpu_en low just after the
  // edge that leaves DONE, so the next call runs back-to-back.
  task automatic do_req(input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat);
    issue(wen, addr, wd);
    lat = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      lat++;
      if (lat > 300) begin
        $display("FAIL req_timeout: got no completion for addr %h required one", addr);
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    cpu_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test required one");
    $fatal(1);
  end

  int lat;

  initial begin
    resetn = 1'b0; cpu_en = 1'b1; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
    ref_mem[30'h07F0_0000] = 32'hDEAD_BEEF;
    slv_mem[30'h07F0_0000] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_stall_en1", 32'(cpu_stall), 1);
    cpu_en = 1'b0; #1;
    chk("rst_stall_en0", 32'(cpu_stall), 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // zero-wait latency, boot-vector read, byte write, read-back
    do_req(4'h0, 32'h1FC0_0000, 32'h0, lat);         chk("rd_latency", lat, 3);
    do_req(4'b0100, 32'h0000_1012, 32'h00AB_0000, lat); chk("wr_latency", lat, WR_LAT);
    do_req(4'h0, 32'h0000_1010, 32'h0, lat);         chk("rd_after_wr_latency", lat, 3);
    do_req(4'hF, 32'h0000_1010, 32'h1234_5678, lat); chk("wr_word_latency", lat, WR_LAT);

    // reset while the read waits in the R phase
    hold_r = 1'b1;
    issue(4'h0, 32'h0000_2000, 32'h0);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!rready && n < 50);
      chk("reach_rd_r", 32'(rready), 1);
    end
    resetn = 1'b0; #1;
    chk("midrst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 0);
    chk("midrst_stall_en1", 32'(cpu_stall), 1);
    cpu_en = 1'b0; #1;
    chk("midrst_stall_en0", 32'(cpu_stall), 0);
    exp_ar.delete(); exp_done.delete();
    repeat (2) @(negedge clk);
    hold_r = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    do_req(4'h0, 32'h0000_1010, 32'h0, lat);         chk("post_rst_rd_latency", lat, 3);

    // randomized traffic with random slave delays and response codes
    zero_wait = 1'b0;
    for (int i = 0; i < 80; i++) begin
      logic [3:0]  wen;
      logic [31:0] addr, wd;
      int gap;
      gap  = $urandom_range(0, 3);
      if (gap > 1) begin repeat (gap - 1) @(posedge clk); #1; end
      wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      addr = 32'h2000_0000 | 32'($urandom_range(0, 127));
      wd   = $urandom;
      do_req(wen, addr, wd, lat);
    end

    repeat (30) @(negedge clk);
    chk("left_ar", 32'(exp_ar.size()), 0);
    chk("left_aw", 32'(exp_aw.size()), 0);
    chk("left_w", 32'(exp_w.size()), 0);
    chk("left_done", 32'(exp_done.size()), 0);
    chk("idle_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
